// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the 5-stage core pipeline control.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         DEF_DRAIN_CYCLES = 3;
  localparam int         DEF_MEM_TIMEOUT  = 255;

  // latchn order {if_id, id_ex, ex_mem, mem_wb}; flush order {if_id, id_ex}
  typedef struct packed {
    logic       pc_we;
    logic       redirect;
    logic [3:0] latchn;
    logic [1:0] flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, redirect: 1'b0, latchn: 4'b0000, flush: 2'b00};
  localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, redirect: 1'b0, latchn: 4'b1111, flush: 2'b00};
  localparam ctrl_t CTRL_REDIR  = '{pc_we: 1'b1, redirect: 1'b1, latchn: 4'b0000, flush: 2'b11};
  localparam ctrl_t CTRL_HENTRY = '{pc_we: 1'b0, redirect: 1'b0, latchn: 4'b0000, flush: 2'b10};
  localparam ctrl_t CTRL_DRAIN  = '{pc_we: 1'b0, redirect: 1'b0, latchn: 4'b0000, flush: 2'b11};
  localparam ctrl_t CTRL_BUBBLE = '{pc_we: 1'b0, redirect: 1'b0, latchn: 4'b1000, flush: 2'b01};
  localparam ctrl_t CTRL_RESET  = '{pc_we: 1'b0, redirect: 1'b0, latchn: 4'b1111, flush: 2'b11};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use and branch-mispredict detection; kept separate for reuse by forwarding.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_use_rs1,
  input  logic       ifid_use_rs2,
  input  logic       idex_valid,
  input  logic       idex_is_load,
  input  logic [4:0] idex_rd,
  input  logic       ex_br_resolved,
  input  logic       ex_br_taken,
  input  logic       ex_bpr,
  output logic       load_use,
  output logic       mispredict
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit    = ifid_use_rs1 & (idex_rd == ifid_rs1);
  assign rs2_hit    = ifid_use_rs2 & (idex_rd == ifid_rs2);
  // x0 never carries a real dependency
  assign load_use   = idex_valid & idex_is_load & (idex_rd != REG_ZERO) & (rs1_hit | rs2_hit);
  assign mispredict = ex_br_resolved & (ex_br_taken ^ ex_bpr);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline controller: latch holds, flushes, PC control, dmem-wait timeout, halt drain, stall counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             id_halt_cand,
  input  logic             idex_valid,
  input  logic             idex_is_load,
  input  logic [4:0]       idex_rd,
  input  logic             ex_br_resolved,
  input  logic             ex_br_taken,
  input  logic             ex_bpr,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             redirect,
  output logic             if_id_latchn,
  output logic             id_ex_latchn,
  output logic             ex_mem_latchn,
  output logic             mem_wb_latchn,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halt,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t           state_q, state_d, eff_st;
  logic [WW-1:0]    wait_q, wait_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             ret_drain_q, ret_drain_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q;
  logic             load_use, mispredict, mem_busy, stall_inc;
  ctrl_t            c;

  hazard_detect u_hd (
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2),
    .ifid_use_rs1   (ifid_use_rs1),
    .ifid_use_rs2   (ifid_use_rs2),
    .idex_valid     (idex_valid),
    .idex_is_load   (idex_is_load),
    .idex_rd        (idex_rd),
    .ex_br_resolved (ex_br_resolved),
    .ex_br_taken    (ex_br_taken),
    .ex_bpr         (ex_bpr),
    .load_use       (load_use),
    .mispredict     (mispredict)
  );

  assign mem_busy = dmem_req & ~dmem_ready;
  // The cycle dmem_ready arrives behaves as the state we were in before the wait
  assign eff_st   = (state_q == ST_MEM_WAIT) ? (ret_drain_q ? ST_DRAIN : ST_RUN) : state_q;

  always_comb begin
    c           = CTRL_NORMAL;
    state_d     = eff_st;
    wait_d      = wait_q;
    drain_d     = drain_q;
    ret_drain_d = ret_drain_q;
    err_d       = err_q;
    if (state_q == ST_HALTED) begin
      c = CTRL_FREEZE;
    end else if (mem_busy) begin
      c = CTRL_FREEZE;
      if (state_q != ST_MEM_WAIT) ret_drain_d = (state_q == ST_DRAIN);
      if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = ST_HALTED;
        wait_d  = '0;
      end else begin
        state_d = ST_MEM_WAIT;
        wait_d  = wait_q + 1'b1;
      end
    end else begin
      wait_d = '0;
      if (eff_st == ST_DRAIN) begin
        c = CTRL_DRAIN;
        if (drain_q != '0) drain_d = drain_q - 1'b1;
        if (drain_q <= DW'(1)) state_d = ST_HALTED;
      end else if (mispredict) begin
        c = CTRL_REDIR;
      end else if (id_halt_cand) begin
        c       = CTRL_HENTRY;
        state_d = ST_DRAIN;
        drain_d = DW'(DRAIN_CYCLES);
      end else if (load_use) begin
        c = CTRL_BUBBLE;
      end
    end
    if (!RSTn) c = CTRL_RESET;
  end

  assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) &&
                     !c.pc_we && !c.redirect && !(&stall_q);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      drain_q     <= '0;
      ret_drain_q <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      drain_q     <= drain_d;
      ret_drain_q <= ret_drain_d;
      err_q       <= err_d;
      if (stall_inc) stall_q <= stall_q + 1'b1;
    end
  end

  assign pc_we         = c.pc_we;
  assign redirect      = c.redirect;
  assign if_id_latchn  = c.latchn[3];
  assign id_ex_latchn  = c.latchn[2];
  assign ex_mem_latchn = c.latchn[1];
  assign mem_wb_latchn = c.latchn[0];
  assign if_id_flush   = c.flush[1];
  assign id_ex_flush   = c.flush[0];
  assign halt          = RSTn & (state_q == ST_HALTED);
  assign mem_err       = RSTn & err_q;
  assign stall_cnt     = RSTn ? stall_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for RUN decisions plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 3;

  // {pc_we, redirect, if_id_l, id_ex_l, ex_mem_l, mem_wb_l, if_id_f, id_ex_f, halt, mem_err}
  localparam logic [9:0] O_NORM = 10'b10_0000_00_00;
  localparam logic [9:0] O_LU   = 10'b00_1000_01_00;
  localparam logic [9:0] O_MISP = 10'b11_0000_11_00;
  localparam logic [9:0] O_FRZ  = 10'b00_1111_00_00;
  localparam logic [9:0] O_HENT = 10'b00_0000_10_00;
  localparam logic [9:0] O_DRN  = 10'b00_0000_11_00;
  localparam logic [9:0] O_HLT  = 10'b00_1111_00_10;
  localparam logic [9:0] O_HERR = 10'b00_1111_00_11;
  localparam logic [9:0] O_RST  = 10'b00_1111_11_00;

  logic CLK = 1'b0;
  logic RSTn;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic ifid_use_rs1, ifid_use_rs2, id_halt_cand, idex_valid, idex_is_load;
  logic ex_br_resolved, ex_br_taken, ex_bpr, dmem_req, dmem_ready;
  logic pc_we, redirect, if_id_latchn, id_ex_latchn, ex_mem_latchn, mem_wb_latchn;
  logic if_id_flush, id_ex_flush, halt, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [9:0] outs;

  int checks = 0;
  int failures = 0;
  int exp_stall;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .id_halt_cand(id_halt_cand), .idex_valid(idex_valid),
    .idex_is_load(idex_is_load), .idex_rd(idex_rd),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken), .ex_bpr(ex_bpr),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .redirect(redirect),
    .if_id_latchn(if_id_latchn), .id_ex_latchn(id_ex_latchn),
    .ex_mem_latchn(ex_mem_latchn), .mem_wb_latchn(mem_wb_latchn),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halt(halt), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  assign outs = {pc_we, redirect, if_id_latchn, id_ex_latchn, ex_mem_latchn,
                 mem_wb_latchn, if_id_flush, id_ex_flush, halt, mem_err};

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       hc;
    logic       v;
    logic       ld;
    logic [4:0] rd;
    logic       br;
    logic       tk;
    logic       bp;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic hc,
                              input logic v, input logic ld, input logic [4:0] rd,
                              input logic br, input logic tk, input logic bp,
                              input logic [9:0] exp);
    vec_t r;
    r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.hc = hc; r.v = v; r.ld = ld;
    r.rd = rd; r.br = br; r.tk = tk; r.bp = bp; r.exp = exp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ifid_rs1 = 0; ifid_rs2 = 0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    id_halt_cand = 0; idex_valid = 0; idex_is_load = 0; idex_rd = 0;
    ex_br_resolved = 0; ex_br_taken = 0; ex_bpr = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic apply(input vec_t v);
    ifid_rs1 = v.rs1; ifid_rs2 = v.rs2; ifid_use_rs1 = v.u1; ifid_use_rs2 = v.u2;
    id_halt_cand = v.hc; idex_valid = v.v; idex_is_load = v.ld; idex_rd = v.rd;
    ex_br_resolved = v.br; ex_br_taken = v.tk; ex_bpr = v.bp;
    dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    idle();
    tick();
    RSTn = 1'b1;
  endtask

  task automatic set_lw_x5();
    idle();
    idex_valid = 1; idex_is_load = 1; idex_rd = 5; ifid_rs1 = 5; ifid_use_rs1 = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                rs1 rs2 u1 u2 hc v  ld rd br tk bp exp
    vecs[0]  = mk(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, O_NORM);
    vecs[1]  = mk(5'd5, 5'd0, 1, 0, 0, 1, 1, 5'd5, 0, 0, 0, O_LU);
    vecs[2]  = mk(5'd5, 5'd0, 1, 0, 0, 0, 0, 5'd0, 0, 0, 0, O_NORM);
    vecs[3]  = mk(5'd1, 5'd7, 0, 1, 0, 1, 1, 5'd7, 0, 0, 0, O_LU);
    vecs[4]  = mk(5'd0, 5'd0, 1, 1, 0, 1, 1, 5'd0, 0, 0, 0, O_NORM);
    vecs[5]  = mk(5'd5, 5'd5, 0, 0, 0, 1, 1, 5'd5, 0, 0, 0, O_NORM);
    vecs[6]  = mk(5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0, 0, 0, O_NORM);
    vecs[7]  = mk(5'd5, 5'd0, 1, 0, 0, 1, 0, 5'd5, 0, 0, 0, O_NORM);
    vecs[8]  = mk(5'd5, 5'd0, 1, 0, 0, 1, 1, 5'd5, 1, 1, 0, O_MISP);
    vecs[9]  = mk(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, 0, 1, O_MISP);
    vecs[10] = mk(5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, 1, 1, O_NORM);
    vecs[11] = mk(5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 1, 1, 0, O_MISP);
    vecs[12] = mk(5'd3, 5'd9, 1, 1, 0, 1, 1, 5'd9, 0, 1, 0, O_LU);

    // reset with hazards active on the inputs
    RSTn = 1'b0;
    set_lw_x5();
    ex_br_resolved = 1; ex_br_taken = 1; dmem_req = 1;
    tick();
    chk("reset_outs", 32'(outs), 32'(O_RST));
    chk("reset_stall", 32'(stall_cnt), 0);
    RSTn = 1'b1;
    idle();
    tick();

    exp_stall = 0;
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
      if (!vecs[i].exp[9] && !vecs[i].exp[8] && exp_stall < 7) exp_stall++;
      tick();
    end
    idle();
    #2;
    chk("table_stall", 32'(stall_cnt), 32'(exp_stall));

    // 4-cycle dmem wait, then resume
    do_reset();
    dmem_req = 1;
    for (int k = 0; k < 4; k++) begin
      #2; chk($sformatf("memwait%0d", k), 32'(outs), 32'(O_FRZ)); tick();
    end
    dmem_ready = 1;
    #2; chk("mem_ready", 32'(outs), 32'(O_NORM)); tick();
    set_lw_x5();
    #2; chk("stall_after_wait", 32'(stall_cnt), 4);
    chk("run_after_wait", 32'(outs), 32'(O_LU));
    tick();
    for (int k = 0; k < 4; k++) tick();
    idle();
    #2; chk("stall_saturate", 32'(stall_cnt), 7);
    tick();

    // halt drain, mispredict ignored in DRAIN, HALTED ignores dmem
    do_reset();
    id_halt_cand = 1;
    #2; chk("halt_entry", 32'(outs), 32'(O_HENT)); tick();
    idle();
    ex_br_resolved = 1; ex_br_taken = 1; ex_bpr = 0;
    for (int k = 0; k < 3; k++) begin
      #2; chk($sformatf("drain%0d", k), 32'(outs), 32'(O_DRN)); tick();
    end
    #2; chk("halted", 32'(outs), 32'(O_HLT));
    chk("stall_drain_hold", 32'(stall_cnt), 1);
    idle();
    dmem_req = 1;
    tick();
    #2; chk("halted_sticky", 32'(outs), 32'(O_HLT));
    tick();

    // drain with a 2-cycle dmem wait in the middle
    do_reset();
    id_halt_cand = 1;
    tick();
    idle();
    #2; chk("dw_drain0", 32'(outs), 32'(O_DRN)); tick();
    dmem_req = 1;
    #2; chk("dw_wait0", 32'(outs), 32'(O_FRZ)); tick();
    #2; chk("dw_wait1", 32'(outs), 32'(O_FRZ)); tick();
    dmem_ready = 1;
    #2; chk("dw_drain1", 32'(outs), 32'(O_DRN)); tick();
    idle();
    #2; chk("dw_drain2", 32'(outs), 32'(O_DRN)); tick();
    #2; chk("dw_halted", 32'(outs), 32'(O_HLT)); tick();

    // reset during DRAIN aborts it
    do_reset();
    id_halt_cand = 1;
    tick();
    idle();
    #2; chk("rd_drain", 32'(outs), 32'(O_DRN));
    RSTn = 1'b0;
    #1; chk("rd_reset", 32'(outs), 32'(O_RST));
    tick();
    RSTn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2; chk($sformatf("rd_run%0d", k), 32'(outs), 32'(O_NORM)); tick();
    end

    // dmem timeout after 8 wait cycles
    do_reset();
    dmem_req = 1;
    for (int k = 0; k < 8; k++) begin
      #2; chk($sformatf("to_wait%0d", k), 32'(outs), 32'(O_FRZ)); tick();
    end
    #2; chk("to_halted_err", 32'(outs), 32'(O_HERR));
    idle();
    tick();
    #2; chk("to_err_sticky", 32'(outs), 32'(O_HERR));
    RSTn = 1'b0;
    #2; chk("to_reset", 32'(outs), 32'(O_RST));
    tick();
    RSTn = 1'b1;
    #2; chk("to_run", 32'(outs), 32'(O_NORM));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
